// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline control unit.
//   - stall codes driven onto every pipeline register
//   - pending-redirect FSM state encodings
//   - per-cycle counter event bundle
//   - helper choosing the PC register code while a redirect is in flight
package pipe_ctrl_pkg;

  // Width of an architectural register address
  localparam int REG_AW = 5;

  // Per-register control code
  typedef enum logic [1:0] {
    STALL_NEXT = 2'b00,
    STALL_KEEP = 2'b01,
    STALL_ZERO = 2'b10
  } stall_code_e;

  // Pending-redirect state machine
  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_PEND_CTRL = 2'b01,
    ST_PEND_EXC  = 2'b10
  } pend_state_e;

  // One flag per event counter, raised for the current cycle
  typedef struct packed {
    logic redirect;
    logic loaduse;
    logic fetch;
    logic backend;
  } cnt_evt_t;

  // During a redirect the PC register loads the target unless fetch is
  // stalled, in which case it holds and the redirect is deferred.
  function automatic stall_code_e lead_code(input logic fetch_stall);
    if (fetch_stall) begin
      return STALL_KEEP;
    end else begin
      return STALL_NEXT;
    end
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: bundle between the datapath and the pipeline control unit.
//   master modport : datapath side (drives hazard/stall/redirect requests,
//                    receives per-register codes, redirect and counters)
//   slave modport  : pipe_ctrl side
// Signals:
//   src_rena/src_addr      decode source ports (5-bit address each)
//   prod_late/prod_waddr   late-result producers and their destinations
//   stall_req              per-stage stall requests, bit 0 = fetch
//   br_taken/jump/ctrl_target  resolved control redirect
//   exc_valid/exc_target   trap redirect from writeback
//   cnt_clr                synchronous counter clear
//   stall_ctrl             2-bit code per pipeline register (reg j at [2j+1:2j])
//   redirect_valid/redirect_pc  PC redirect this cycle
//   cnt_*                  saturating event counters
interface pipe_ctrl_if #(
  parameter int NSTAGE = 5,
  parameter int XLEN   = 64,
  parameter int NSRC   = 2,
  parameter int NPROD  = 2,
  parameter int CNT_W  = 32
);
  import pipe_ctrl_pkg::*;

  logic [NSRC-1:0]         src_rena;
  logic [REG_AW*NSRC-1:0]  src_addr;
  logic [NPROD-1:0]        prod_late;
  logic [REG_AW*NPROD-1:0] prod_waddr;
  logic [NSTAGE-1:0]       stall_req;
  logic                    br_taken;
  logic                    jump;
  logic [XLEN-1:0]         ctrl_target;
  logic                    exc_valid;
  logic [XLEN-1:0]         exc_target;
  logic                    cnt_clr;
  logic [2*NSTAGE-1:0]     stall_ctrl;
  logic                    redirect_valid;
  logic [XLEN-1:0]         redirect_pc;
  logic [CNT_W-1:0]        cnt_redirect;
  logic [CNT_W-1:0]        cnt_loaduse;
  logic [CNT_W-1:0]        cnt_fetch;
  logic [CNT_W-1:0]        cnt_backend;

  modport master (
    output src_rena, src_addr, prod_late, prod_waddr, stall_req,
           br_taken, jump, ctrl_target, exc_valid, exc_target, cnt_clr,
    input  stall_ctrl, redirect_valid, redirect_pc,
           cnt_redirect, cnt_loaduse, cnt_fetch, cnt_backend
  );

  modport slave (
    input  src_rena, src_addr, prod_late, prod_waddr, stall_req,
           br_taken, jump, ctrl_target, exc_valid, exc_target, cnt_clr,
    output stall_ctrl, redirect_valid, redirect_pc,
           cnt_redirect, cnt_loaduse, cnt_fetch, cnt_backend
  );

endinterface

// File: rtl/pipe_ctrl_hazard_cmp.sv
// hazard_cmp: load-use detector. Compares every decode source port against
// every late producer and reduces the matches to a single flag.
// Ports:
//   src_rena   in  NSRC          source port i reads a register
//   src_addr   in  5*NSRC        source addresses, port i at [5i+4:5i]
//   prod_late  in  NPROD         producer k result not yet forwardable
//   prod_waddr in  5*NPROD       producer destination addresses
//   loaduse    out 1             some enabled source waits on a late producer
module hazard_cmp
  import pipe_ctrl_pkg::*;
#(
  parameter int NSRC  = 2,
  parameter int NPROD = 2
) (
  input  logic [NSRC-1:0]         src_rena,
  input  logic [REG_AW*NSRC-1:0]  src_addr,
  input  logic [NPROD-1:0]        prod_late,
  input  logic [REG_AW*NPROD-1:0] prod_waddr,
  output logic                    loaduse
);

  logic [NSRC*NPROD-1:0] match_s;

  // Register 0 is hardwired to zero and never creates a dependency.
  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    for (genvar gk = 0; gk < NPROD; gk++) begin : g_prod
      assign match_s[gi*NPROD+gk] =
          src_rena[gi] & prod_late[gk] &
          (src_addr[REG_AW*gi +: REG_AW] == prod_waddr[REG_AW*gk +: REG_AW]) &
          (src_addr[REG_AW*gi +: REG_AW] != {REG_AW{1'b0}});
    end
  end

  assign loaduse = |match_s;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush generation for an NSTAGE-register in-order pipeline.
// Drives a 2-bit NEXT/KEEP/ZERO code to each pipeline register (reg 0 = PC),
// issues PC redirects for traps and control transfers, defers a redirect
// while fetch is stalled, and counts redirect/stall activity.
// Ports:
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset
//   bus    pipe_ctrl_if.slave: hazard, stall and redirect requests in;
//          stall_ctrl, redirect_valid/redirect_pc and counters out
// All outputs are combinational from the inputs and the registered state.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE        = 5,
  parameter int XLEN          = 64,
  parameter int NSRC          = 2,
  parameter int NPROD         = 2,
  parameter int DEC_STAGE     = 1,
  parameter int RESOLVE_STAGE = 3,
  parameter int CNT_W         = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.slave  bus
);

  logic                loaduse_s;
  logic [NSTAGE-1:0]   sv_s;
  int                  hi_idx_s;
  logic                ctrl_live_s;
  logic                fetch_stall_s;
  pend_state_e         state_r;
  pend_state_e         state_nxt_s;
  logic [XLEN-1:0]     pend_tgt_r;
  logic [XLEN-1:0]     pend_tgt_nxt_s;
  logic [2*NSTAGE-1:0] stall_ctrl_s;
  logic                redirect_valid_s;
  logic [XLEN-1:0]     redirect_pc_s;
  cnt_evt_t            evt_s;
  logic [CNT_W-1:0]    cnt_redirect_r;
  logic [CNT_W-1:0]    cnt_loaduse_r;
  logic [CNT_W-1:0]    cnt_fetch_r;
  logic [CNT_W-1:0]    cnt_backend_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  hazard_cmp #(
    .NSRC  (NSRC),
    .NPROD (NPROD)
  ) u_hazard_cmp (
    .src_rena   (bus.src_rena),
    .src_addr   (bus.src_addr),
    .prod_late  (bus.prod_late),
    .prod_waddr (bus.prod_waddr),
    .loaduse    (loaduse_s)
  );

  // A trap from writeback suppresses any control transfer in the same cycle.
  assign ctrl_live_s   = (bus.br_taken | bus.jump) & ~bus.exc_valid;
  assign fetch_stall_s = bus.stall_req[0];

  // Effective stall vector: load-use appears as a stall of the decode stage
  always_comb begin
    sv_s            = bus.stall_req;
    sv_s[DEC_STAGE] = bus.stall_req[DEC_STAGE] | loaduse_s;
  end

  // Index of the youngest-stage (highest) stall, -1 when none
  always_comb begin
    hi_idx_s = -1;
    for (int r = 0; r < NSTAGE; r++) begin
      if (sv_s[r]) begin
        hi_idx_s = r;
      end else begin
        hi_idx_s = hi_idx_s;
      end
    end
  end

  // Priority encoder: register codes, redirect strobe, FSM next state, events
  always_comb begin
    state_nxt_s      = state_r;
    pend_tgt_nxt_s   = pend_tgt_r;
    stall_ctrl_s     = {NSTAGE{STALL_NEXT}};
    redirect_valid_s = 1'b0;
    evt_s            = '0;

    if (bus.exc_valid || (state_r == ST_PEND_EXC)) begin
      // Trap: squash everything behind the PC
      for (int r = 0; r < NSTAGE; r++) begin
        if (r == 0) begin
          stall_ctrl_s[2*r +: 2] = lead_code(fetch_stall_s);
        end else begin
          stall_ctrl_s[2*r +: 2] = STALL_ZERO;
        end
      end
      redirect_valid_s = ~fetch_stall_s;
      if (bus.exc_valid) begin
        // A fresh trap also overrides any deferred control redirect.
        if (fetch_stall_s) begin
          state_nxt_s    = ST_PEND_EXC;
          pend_tgt_nxt_s = bus.exc_target;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end else if (!fetch_stall_s) begin
        state_nxt_s = ST_IDLE;
      end else begin
        state_nxt_s = state_r;
      end
    end else if ((state_r == ST_PEND_CTRL) || ctrl_live_s) begin
      // Control transfer: squash up to the resolve stage, older work drains
      for (int r = 0; r < NSTAGE; r++) begin
        if (r == 0) begin
          stall_ctrl_s[2*r +: 2] = lead_code(fetch_stall_s);
        end else if (r <= RESOLVE_STAGE) begin
          stall_ctrl_s[2*r +: 2] = STALL_ZERO;
        end else begin
          stall_ctrl_s[2*r +: 2] = STALL_NEXT;
        end
      end
      redirect_valid_s = ~fetch_stall_s;
      if (state_r == ST_PEND_CTRL) begin
        // A new control redirect while one is pending is dropped.
        if (!fetch_stall_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end else if (fetch_stall_s) begin
        state_nxt_s    = ST_PEND_CTRL;
        pend_tgt_nxt_s = bus.ctrl_target;
      end else begin
        state_nxt_s = ST_IDLE;
      end
    end else if (|sv_s) begin
      // Freeze everything up to the youngest stall and insert a bubble after it
      for (int r = 0; r < NSTAGE; r++) begin
        if (r <= hi_idx_s) begin
          stall_ctrl_s[2*r +: 2] = STALL_KEEP;
        end else if (r == hi_idx_s + 1) begin
          stall_ctrl_s[2*r +: 2] = STALL_ZERO;
        end else begin
          stall_ctrl_s[2*r +: 2] = STALL_NEXT;
        end
      end
      evt_s.loaduse = loaduse_s & (hi_idx_s == DEC_STAGE);
      evt_s.backend = (hi_idx_s > DEC_STAGE);
      evt_s.fetch   = fetch_stall_s;
    end else begin
      evt_s.fetch = fetch_stall_s;
    end

    evt_s.redirect = redirect_valid_s;
  end

  // Redirect target: live trap first, then the deferred target, then control
  always_comb begin
    if (bus.exc_valid) begin
      redirect_pc_s = bus.exc_target;
    end else if (state_r != ST_IDLE) begin
      redirect_pc_s = pend_tgt_r;
    end else begin
      redirect_pc_s = bus.ctrl_target;
    end
  end

  // Pending-redirect state and target registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      pend_tgt_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      pend_tgt_r <= pend_tgt_nxt_s;
    end
  end

  // Saturating event counters; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_redirect_r <= '0;
      cnt_loaduse_r  <= '0;
      cnt_fetch_r    <= '0;
      cnt_backend_r  <= '0;
    end else if (bus.cnt_clr) begin
      cnt_redirect_r <= '0;
      cnt_loaduse_r  <= '0;
      cnt_fetch_r    <= '0;
      cnt_backend_r  <= '0;
    end else begin
      if (evt_s.redirect) cnt_redirect_r <= sat_inc(cnt_redirect_r);
      else                cnt_redirect_r <= cnt_redirect_r;
      if (evt_s.loaduse)  cnt_loaduse_r  <= sat_inc(cnt_loaduse_r);
      else                cnt_loaduse_r  <= cnt_loaduse_r;
      if (evt_s.fetch)    cnt_fetch_r    <= sat_inc(cnt_fetch_r);
      else                cnt_fetch_r    <= cnt_fetch_r;
      if (evt_s.backend)  cnt_backend_r  <= sat_inc(cnt_backend_r);
      else                cnt_backend_r  <= cnt_backend_r;
    end
  end

  assign bus.stall_ctrl     = stall_ctrl_s;
  assign bus.redirect_valid = redirect_valid_s;
  assign bus.redirect_pc    = redirect_pc_s;
  assign bus.cnt_redirect   = cnt_redirect_r;
  assign bus.cnt_loaduse    = cnt_loaduse_r;
  assign bus.cnt_fetch      = cnt_fetch_r;
  assign bus.cnt_backend    = cnt_backend_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios followed by randomized traffic, every
// cycle compared against a behavioural model of the control rules.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int NSTAGE        = 5;
  localparam int XLEN          = 64;
  localparam int NSRC          = 2;
  localparam int NPROD         = 2;
  localparam int DEC_STAGE     = 1;
  localparam int RESOLVE_STAGE = 3;
  localparam int CNT_W         = 4;
  localparam int CNT_MAX       = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(
    .NSTAGE(NSTAGE), .XLEN(XLEN), .NSRC(NSRC), .NPROD(NPROD), .CNT_W(CNT_W)
  ) bus ();

  pipe_ctrl #(
    .NSTAGE(NSTAGE), .XLEN(XLEN), .NSRC(NSRC), .NPROD(NPROD),
    .DEC_STAGE(DEC_STAGE), .RESOLVE_STAGE(RESOLVE_STAGE), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model state: pending kind (0 none, 1 control, 2 trap), its target, counters
  int              m_pend;
  logic [XLEN-1:0] m_tgt;
  int              m_cnt [4];   // redirect, loaduse, fetch, backend
  int              m_np;
  logic [XLEN-1:0] m_nt;
  logic [3:0]      m_ev;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    bus.src_rena    = '0;
    bus.src_addr    = '0;
    bus.prod_late   = '0;
    bus.prod_waddr  = '0;
    bus.stall_req   = '0;
    bus.br_taken    = 1'b0;
    bus.jump        = 1'b0;
    bus.ctrl_target = '0;
    bus.exc_valid   = 1'b0;
    bus.exc_target  = '0;
    bus.cnt_clr     = 1'b0;
  endtask

  // Behavioural model: each register gets KEEP up to keep_hi, ZERO in
  // [zlo..zhi], NEXT elsewhere.
  task automatic model_eval(output logic [2*NSTAGE-1:0] sc, output logic rv,
                            output logic [XLEN-1:0] pc);
    logic lu;
    logic [NSTAGE-1:0] sv;
    logic [4:0] a, w;
    int s, keep_hi, zlo, zhi;
    bit f, exc_act, ctl_act;
    lu = 1'b0;
    for (int i = 0; i < NSRC; i++)
      for (int k = 0; k < NPROD; k++) begin
        a = bus.src_addr[5*i +: 5];
        w = bus.prod_waddr[5*k +: 5];
        if (bus.src_rena[i] && bus.prod_late[k] && a == w && a != 5'd0) lu = 1'b1;
      end
    sv = bus.stall_req;
    if (lu) sv[DEC_STAGE] = 1'b1;
    s = -1;
    for (int j = 0; j < NSTAGE; j++) if (sv[j]) s = j;
    f       = bus.stall_req[0];
    exc_act = bus.exc_valid || (m_pend == 2);
    ctl_act = !exc_act && ((m_pend == 1) || bus.br_taken || bus.jump);
    if (exc_act || ctl_act) begin
      keep_hi = f ? 0 : -1;
      zlo = 1;
      zhi = exc_act ? NSTAGE - 1 : RESOLVE_STAGE;
      rv  = !f;
    end else begin
      rv = 1'b0;
      keep_hi = s;
      zlo = (s < 0) ? 1 : s + 1;
      zhi = (s < 0) ? 0 : s + 1;
    end
    for (int j = 0; j < NSTAGE; j++) begin
      if (j <= keep_hi)            sc[2*j +: 2] = 2'b01;
      else if (j >= zlo && j <= zhi) sc[2*j +: 2] = 2'b10;
      else                         sc[2*j +: 2] = 2'b00;
    end
    pc = bus.exc_valid ? bus.exc_target : ((m_pend != 0) ? m_tgt : bus.ctrl_target);
    m_np = m_pend;
    m_nt = m_tgt;
    if (bus.exc_valid) begin
      m_np = f ? 2 : 0;
      if (f) m_nt = bus.exc_target;
    end else if (m_pend != 0) begin
      if (!f) m_np = 0;
    end else if (ctl_act && f) begin
      m_np = 1;
      m_nt = bus.ctrl_target;
    end
    m_ev = 4'b0000;
    m_ev[0] = rv;
    if (!exc_act && !ctl_act) begin
      m_ev[1] = lu && (s == DEC_STAGE);
      m_ev[2] = f;
      m_ev[3] = (s > DEC_STAGE);
    end
  endtask

  task automatic compare();
    logic [2*NSTAGE-1:0] sc;
    logic rv;
    logic [XLEN-1:0] pc;
    model_eval(sc, rv, pc);
    check_eq("stall_ctrl", 64'(bus.stall_ctrl), 64'(sc));
    check_eq("redirect_valid", 64'(bus.redirect_valid), 64'(rv));
    check_eq("redirect_pc", bus.redirect_pc, pc);
    check_eq("cnt_redirect", 64'(bus.cnt_redirect), 64'(m_cnt[0]));
    check_eq("cnt_loaduse", 64'(bus.cnt_loaduse), 64'(m_cnt[1]));
    check_eq("cnt_fetch", 64'(bus.cnt_fetch), 64'(m_cnt[2]));
    check_eq("cnt_backend", 64'(bus.cnt_backend), 64'(m_cnt[3]));
  endtask

  task automatic advance();
    m_pend = m_np;
    m_tgt  = m_nt;
    for (int c = 0; c < 4; c++) begin
      if (bus.cnt_clr) m_cnt[c] = 0;
      else if (m_ev[c] && m_cnt[c] < CNT_MAX) m_cnt[c] = m_cnt[c] + 1;
    end
  endtask

  // Entered one time unit after a rising edge with inputs already driven
  task automatic step();
    #2;
    compare();
    advance();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    #1;
    m_pend = 0;
    m_tgt  = '0;
    for (int c = 0; c < 4; c++) m_cnt[c] = 0;
    compare();
    @(posedge clk);
    #1;
    compare();
    rst_n = 1'b1;
  endtask

  task automatic randomize_inputs();
    logic [NSTAGE-1:0] st;
    bus.src_rena   = 2'($urandom_range(0, 3));
    bus.src_addr   = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
    bus.prod_late  = 2'($urandom_range(0, 3));
    bus.prod_waddr = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
    for (int j = 0; j < NSTAGE; j++) st[j] = ($urandom_range(0, 5) == 0);
    bus.stall_req   = st;
    bus.br_taken    = ($urandom_range(0, 4) == 0);
    bus.jump        = ($urandom_range(0, 9) == 0);
    bus.ctrl_target = {$urandom, $urandom};
    bus.exc_valid   = ($urandom_range(0, 11) == 0);
    bus.exc_target  = {$urandom, $urandom};
    bus.cnt_clr     = ($urandom_range(0, 39) == 0);
  endtask

  initial begin
    set_idle();
    reset_dut();

    // Idle after reset
    #1;
    check_eq("reset_stall_ctrl", 64'(bus.stall_ctrl), 64'd0);
    check_eq("reset_redirect_valid", 64'(bus.redirect_valid), 64'd0);
    check_eq("reset_redirect_pc", bus.redirect_pc, 64'd0);
    step();
    step();

    // Load-use on source 0 against producer 0
    bus.prod_late = 2'b01; bus.prod_waddr = 10'd5;
    bus.src_rena  = 2'b01; bus.src_addr   = 10'd5;
    #1;
    check_eq("loaduse_codes", 64'(bus.stall_ctrl), 64'(10'b00_00_10_01_01));
    for (int n = 0; n < 3; n++) step();
    set_idle();
    #1;
    check_eq("loaduse_count", 64'(bus.cnt_loaduse), 64'd3);
    bus.cnt_clr = 1'b1;
    step();
    set_idle();

    // Branch with fetch free
    bus.br_taken = 1'b1; bus.ctrl_target = 64'h8000_0100;
    #1;
    check_eq("br_valid", 64'(bus.redirect_valid), 64'd1);
    check_eq("br_pc", bus.redirect_pc, 64'h8000_0100);
    check_eq("br_codes", 64'(bus.stall_ctrl), 64'(10'b00_10_10_10_00));
    step();
    set_idle();
    #1;
    check_eq("br_cnt_redirect", 64'(bus.cnt_redirect), 64'd1);
    step();

    // Branch deferred by a 3-cycle fetch stall
    bus.br_taken = 1'b1; bus.ctrl_target = 64'h8000_0200; bus.stall_req = 5'b00001;
    step();
    for (int n = 0; n < 2; n++) begin
      bus.br_taken = 1'b0; bus.ctrl_target = 64'hdead_beef_0000_0000;
      #1;
      check_eq("pend_ctrl_no_redirect", 64'(bus.redirect_valid), 64'd0);
      step();
    end
    bus.stall_req = 5'b00000;
    #1;
    check_eq("pend_ctrl_fire", 64'(bus.redirect_valid), 64'd1);
    check_eq("pend_ctrl_pc", bus.redirect_pc, 64'h8000_0200);
    step();
    set_idle();
    step();

    // Trap arriving while a control redirect is pending
    bus.br_taken = 1'b1; bus.ctrl_target = 64'h8000_0300; bus.stall_req = 5'b00001;
    step();
    bus.br_taken = 1'b0; bus.exc_valid = 1'b1; bus.exc_target = 64'h8000_0004;
    #1;
    check_eq("exc_codes", 64'(bus.stall_ctrl), 64'(10'b10_10_10_10_01));
    step();
    bus.exc_valid = 1'b0; bus.exc_target = 64'h0;
    step();
    bus.stall_req = 5'b00000;
    #1;
    check_eq("pend_exc_pc", bus.redirect_pc, 64'h8000_0004);
    step();
    set_idle();
    step();

    // Backend stall dominating a load-use
    bus.stall_req = 5'b01000;
    bus.prod_late = 2'b10; bus.prod_waddr = {5'd7, 5'd0};
    bus.src_rena  = 2'b10; bus.src_addr   = {5'd7, 5'd0};
    #1;
    check_eq("backend_codes", 64'(bus.stall_ctrl), 64'(10'b10_01_01_01_01));
    step();
    step();
    set_idle();
    step();

    // Counter saturation and clear
    bus.cnt_clr = 1'b1;
    step();
    set_idle();
    bus.jump = 1'b1; bus.ctrl_target = 64'h40;
    for (int n = 0; n < 20; n++) step();
    set_idle();
    #1;
    check_eq("sat_cnt_redirect", 64'(bus.cnt_redirect), 64'(CNT_MAX));
    bus.cnt_clr = 1'b1;
    step();
    bus.cnt_clr = 1'b0;
    #1;
    check_eq("clr_cnt_redirect", 64'(bus.cnt_redirect), 64'd0);
    step();

    // Reset while a trap redirect is pending discards it
    bus.exc_valid = 1'b1; bus.exc_target = 64'h8000_0008; bus.stall_req = 5'b00001;
    step();
    bus.exc_valid = 1'b0;
    reset_dut();
    bus.stall_req = 5'b00000;
    #1;
    check_eq("post_reset_no_redirect", 64'(bus.redirect_valid), 64'd0);
    step();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      randomize_inputs();
      if (n == 1500) reset_dut();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
